// File: rtl/sine_plotter.sv
// Two-stage pixel pipeline that plots a scrolling sine trace in a 256-row window.
// A small HOLD/RUN FSM advances the horizontal phase offset once every `speed` frames.
module sine_plotter #(
  parameter int          TOP_ROW     = 176,
  parameter logic [11:0] TRACE_COLOR = 12'h0F0,
  parameter logic [11:0] AXIS_COLOR  = 12'h444
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_tick,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        video_on,
  input  logic        frame_start,
  input  logic [2:0]  speed,
  input  logic        dir,
  output logic [5:0]  phase,
  input  logic [3:0]  amp,
  output logic [11:0] rgb
);

  localparam logic [9:0] TOP      = 10'(TOP_ROW);
  localparam logic [9:0] AXIS_ROW = 10'(TOP_ROW + 127);

  typedef enum logic {HOLD, RUN} state_t;

  state_t      state;
  logic [5:0]  offset;
  logic [2:0]  frame_cnt;
  logic [9:0]  vcount_d;
  logic        von_d;

  logic [9:0]  rel;
  logic        in_win;
  logic [3:0]  lvl;
  logic [11:0] colour;
  logic [5:0]  next_offset;
  logic [2:0]  next_cnt;

  // Column groups of 8 pixels; only the low 6 bits of the group index survive mod 64.
  logic unused_hcount_bits;
  assign unused_hcount_bits = ^{hcount[9], hcount[2:0]};

  always_comb begin
    rel    = vcount_d - TOP;
    in_win = (vcount_d >= TOP) && (rel <= 10'd255);
    lvl    = 4'd15 - rel[7:4];
    colour = 12'h000;
    if (von_d && in_win) begin
      if (lvl == amp)
        colour = TRACE_COLOR;
      else if (vcount_d == AXIS_ROW)
        colour = AXIS_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= 6'd0;
      vcount_d <= 10'd0;
      von_d    <= 1'b0;
      rgb      <= 12'h000;
    end else if (pix_tick) begin
      phase    <= hcount[8:3] + offset;
      vcount_d <= vcount;
      von_d    <= video_on;
      rgb      <= colour;
    end
  end

  // Using >= rather than == lets a speed decrease below frame_cnt step on the next frame.
  always_comb begin
    next_offset = offset;
    next_cnt    = frame_cnt + 3'd1;
    if (frame_cnt >= speed - 3'd1) begin
      next_cnt    = 3'd0;
      next_offset = dir ? offset - 6'd1 : offset + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HOLD;
      offset    <= 6'd0;
      frame_cnt <= 3'd0;
    end else if (frame_start) begin
      case (state)
        HOLD: begin
          if (speed != 3'd0) begin
            state     <= RUN;
            offset    <= next_offset;
            frame_cnt <= next_cnt;
          end
        end
        RUN: begin
          if (speed == 3'd0) begin
            state <= HOLD;
          end else begin
            offset    <= next_offset;
            frame_cnt <= next_cnt;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_sine_plotter.sv
// Scoreboard bench for sine_plotter: a frame/pixel-level model predicts phase and rgb
// for every clock; a separate monitor pops and compares after each edge.
module tb_sine_plotter;

  localparam int TOP_ROW = 176;
  localparam int TRACE   = 12'h0F0;
  localparam int AXIS    = 12'h444;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_tick = 1'b0;
  logic [9:0]  hcount = '0;
  logic [9:0]  vcount = '0;
  logic        video_on = 1'b0;
  logic        frame_start = 1'b0;
  logic [2:0]  speed = '0;
  logic        dir = 1'b0;
  logic [5:0]  phase;
  logic [3:0]  amp;
  logic [11:0] rgb;

  logic [3:0]  sine_tab [64];
  logic        amp_ovr_en = 1'b0;
  logic [3:0]  amp_ovr = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_phase_q[$];
  int exp_rgb_q[$];

  // Reference model state
  int m_phase = 0, m_rgb = 0, m_vcd = 0, m_von = 0, m_offset = 0, m_cnt = 0;

  sine_plotter #(.TOP_ROW(TOP_ROW), .TRACE_COLOR(12'h0F0), .AXIS_COLOR(12'h444)) dut (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .frame_start(frame_start), .speed(speed), .dir(dir),
    .phase(phase), .amp(amp), .rgb(rgb)
  );

  // Behaves as the external sine lookup ROM
  assign amp = amp_ovr_en ? amp_ovr : sine_tab[phase];

  always #5 clk = ~clk;

  function automatic int colour_model(int v, int von, int a);
    int lvl;
    if (von == 0) return 0;
    if (v < TOP_ROW || v > TOP_ROW + 255) return 0;
    lvl = 15 - ((v - TOP_ROW) / 16);
    if (lvl == a) return TRACE;
    if (v == TOP_ROW + 127) return AXIS;
    return 0;
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one clock of inputs, advance the model for the coming edge, and queue its outputs.
  task automatic applyStimulus(input int rst, input int tick, input int hc, input int vc,
                               input int von, input int fs, input int spd, input int d);
    int amp_now;
    reset = rst[0]; pix_tick = tick[0]; hcount = 10'(hc); vcount = 10'(vc);
    video_on = von[0]; frame_start = fs[0]; speed = 3'(spd); dir = d[0];
    amp_now = amp_ovr_en ? int'(amp_ovr) : int'(sine_tab[m_phase]);
    if (rst != 0) begin
      m_phase = 0; m_rgb = 0; m_vcd = 0; m_von = 0; m_offset = 0; m_cnt = 0;
    end else begin
      if (tick != 0) begin
        m_rgb   = colour_model(m_vcd, m_von, amp_now);
        m_phase = (hc / 8 + m_offset) % 64;
        m_vcd   = vc;
        m_von   = von;
      end
      if (fs != 0 && spd != 0) begin
        if (m_cnt >= spd - 1) begin
          m_cnt = 0;
          m_offset = (d != 0) ? (m_offset + 63) % 64 : (m_offset + 1) % 64;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    exp_phase_q.push_back(m_phase);
    exp_rgb_q.push_back(m_rgb);
    @(posedge clk);
    #1;
  endtask

  task automatic pulseFrames(input int n, input int spd, input int d);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, spd, d);
      applyStimulus(0, 0, 0, 0, 0, 0, spd, d);
    end
  endtask

  // Monitor: after every edge the DUT presents phase/rgb; compare to the queued prediction.
  initial begin
    forever begin
      @(posedge clk);
      @(negedge clk);
      if (exp_phase_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL sb_underflow: got no prediction for phase 0x%0h rgb 0x%0h", phase, rgb);
      end else begin
        checkOutput("sb_phase", int'(phase), exp_phase_q.pop_front());
        checkOutput("sb_rgb", int'(rgb), exp_rgb_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) sine_tab[i] = 4'($urandom_range(0, 15));

    // Reset state and first phase computations
    applyStimulus(1, 1, 300, 200, 1, 1, 3, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_phase", int'(phase), 0);
    checkOutput("reset_rgb", int'(rgb), 0);
    applyStimulus(0, 1, 16, 0, 0, 0, 0, 0);
    checkOutput("phase_h16_off0", int'(phase), 2);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    pulseFrames(2, 1, 1);
    applyStimulus(0, 1, 16, 0, 0, 0, 0, 0);
    checkOutput("phase_h16_off62", int'(phase), 0);

    // Trace, blank and axis rows
    amp_ovr_en = 1'b1; amp_ovr = 4'hF;
    applyStimulus(0, 1, 40, 176, 1, 0, 0, 0);
    applyStimulus(0, 1, 40, 176, 1, 0, 0, 0);
    checkOutput("trace_top_row", int'(rgb), 12'h0F0);
    applyStimulus(0, 1, 40, 192, 1, 0, 0, 0);
    applyStimulus(0, 1, 40, 192, 1, 0, 0, 0);
    checkOutput("blank_row_192", int'(rgb), 12'h000);
    amp_ovr = 4'h3;
    applyStimulus(0, 1, 40, 303, 1, 0, 0, 0);
    applyStimulus(0, 1, 40, 303, 1, 0, 0, 0);
    checkOutput("axis_row", int'(rgb), 12'h444);
    applyStimulus(0, 1, 40, 303, 0, 0, 0, 0);
    applyStimulus(0, 1, 40, 303, 0, 0, 0, 0);
    checkOutput("axis_video_off", int'(rgb), 12'h000);
    applyStimulus(0, 0, 40, 176, 1, 0, 0, 0);
    checkOutput("hold_no_tick", int'(rgb), 12'h000);
    amp_ovr_en = 1'b0;

    // Scroll stepping and wrap
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    pulseFrames(4, 2, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 2, 0);
    checkOutput("offset_speed2_4pulses", int'(phase), 2);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    pulseFrames(128, 2, 0);
    applyStimulus(0, 1, 8, 0, 0, 0, 2, 0);
    checkOutput("offset_wrap_128", int'(phase), 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    pulseFrames(1, 1, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 1);
    checkOutput("offset_dec_wrap", int'(phase), 63);
    pulseFrames(10, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("offset_frozen", int'(phase), 63);

    // Speed decrease with frame_cnt already past the new limit
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    pulseFrames(3, 5, 0);
    pulseFrames(1, 2, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 2, 0);
    checkOutput("speed_decrease_step", int'(phase), 1);

    // Reset mid-pipeline discards in-flight pixels
    amp_ovr_en = 1'b1; amp_ovr = 4'hF;
    applyStimulus(0, 1, 100, 176, 1, 0, 0, 0);
    applyStimulus(0, 1, 100, 176, 1, 1, 1, 0);
    applyStimulus(1, 1, 100, 176, 1, 1, 1, 0);
    checkOutput("midreset_phase", int'(phase), 0);
    checkOutput("midreset_rgb", int'(rgb), 0);
    applyStimulus(0, 1, 100, 176, 1, 0, 0, 0);
    checkOutput("post_reset_tick1_rgb", int'(rgb), 0);
    applyStimulus(0, 1, 100, 176, 1, 0, 0, 0);
    checkOutput("post_reset_tick2_rgb", int'(rgb), 12'h0F0);
    amp_ovr_en = 1'b0;

    // Randomized traffic checked only through the scoreboard
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 149) == 0) ? 1 : 0,
                    int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 639)),
                    int'($urandom_range(140, 460)),
                    ($urandom_range(0, 7) != 0) ? 1 : 0,
                    ($urandom_range(0, 5) == 0) ? 1 : 0,
                    int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
